// File: rtl/fwd_scoreboard_if.sv
// rtl/fwd_scoreboard_if.sv - EXE-stage forwarding scoreboard bus interface
//
// Purpose: groups the EXE-stage issue/operand signals and the scoreboard
// responses so the pipeline and the scoreboard share one connection.
//   master (pipeline side): drives freeze, ex_issue, ex_dst, ex_rdy, ex_src,
//                           ex_src_imm, kill1; receives fwd_sel, stall_req,
//                           slot_valid.
//   slave  (scoreboard):    the mirror image of master.
interface fwd_scoreboard_if #(
    parameter int REGW  = 5,
    parameter int NSRC  = 2,
    parameter int DEPTH = 2,
    parameter int FWDW  = 3
);
    logic                        freeze;
    logic                        ex_issue;
    logic [REGW-1:0]             ex_dst;
    logic [FWDW-1:0]             ex_rdy;
    logic [NSRC*REGW-1:0]        ex_src;
    logic [NSRC-1:0]             ex_src_imm;
    logic                        kill1;
    logic [NSRC*(DEPTH+1)-1:0]   fwd_sel;
    logic                        stall_req;
    logic [DEPTH-1:0]            slot_valid;

    modport master (
        output freeze, ex_issue, ex_dst, ex_rdy, ex_src, ex_src_imm, kill1,
        input  fwd_sel, stall_req, slot_valid
    );

    modport slave (
        input  freeze, ex_issue, ex_dst, ex_rdy, ex_src, ex_src_imm, kill1,
        output fwd_sel, stall_req, slot_valid
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - parametrised EXE-stage forwarding/hazard scoreboard
//
// Purpose: tracks in-flight results in a DEPTH-slot shift scoreboard
// (slot 1 = MEM, slot 2 = WB, higher slots = extra late stages), resolves a
// one-hot bypass select per ALU operand and raises a load-use stall when the
// youngest producer of an operand is not yet forwardable.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset (priority over freeze/kill1)
//   bus            fwd_scoreboard_if.slave (issue, operands, fwd_sel,
//                  stall_req, slot_valid)
//   stall_cnt_clr  synchronous clear of the stall counter   (optional)
//   stall_cnt      saturating count of unfrozen stall cycles (optional)
//
// Optional feature: define FWD_SCOREBOARD_STALL_CNT_EN to add the stall
// counter and its two ports.
module fwd_scoreboard #(
    parameter int REGW  = 5,
    parameter int NSRC  = 2,
    parameter int DEPTH = 2,
    parameter int FWDW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    fwd_scoreboard_if.slave      bus
`ifdef FWD_SCOREBOARD_STALL_CNT_EN
    ,
    input  logic                 stall_cnt_clr,
    output logic [31:0]          stall_cnt
`endif
);

    localparam int SELW = DEPTH + 1;

    // Slot k lives at index k; index 1 is the youngest (MEM) entry.
    logic [DEPTH:1]    slotValid;
    logic [REGW-1:0]   slotDst [1:DEPTH];
    logic [FWDW-1:0]   slotRdy [1:DEPTH];

    logic [NSRC*SELW-1:0] fwdSel;
    logic                 stallAny;
    logic                 stallReq;

    // Operand resolution. Slots are scanned oldest-to-youngest so the last
    // hit is the youngest match; an older ready entry can therefore never
    // override a younger one that still holds stale-for-us data.
    always_comb begin
        logic [REGW-1:0] src;
        logic            hit;
        int              winK;
        int              winRdy;
        fwdSel   = '0;
        stallAny = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            src    = bus.ex_src[i*REGW +: REGW];
            hit    = 1'b0;
            winK   = 0;
            winRdy = 0;
            for (int k = DEPTH; k >= 1; k--) begin
                if (slotValid[k] && (slotDst[k] == src) && (src != '0)
                    && !bus.ex_src_imm[i]) begin
                    hit    = 1'b1;
                    winK   = k;
                    winRdy = int'(slotRdy[k]);
                end
            end
            if (hit && (winK < winRdy)) begin
                stallAny           = 1'b1;
                fwdSel[i*SELW]     = 1'b1;
            end else if (hit) begin
                fwdSel[i*SELW + winK] = 1'b1;
            end else begin
                fwdSel[i*SELW]     = 1'b1;
            end
        end
    end

    // A frozen pipe is already stalled; asserting stall too would lose a slot.
    assign stallReq       = stallAny & ~bus.freeze;
    assign bus.stall_req  = stallReq;
    assign bus.fwd_sel    = fwdSel;
    assign bus.slot_valid = slotValid;

    always_ff @(posedge clk) begin
        if (rst) begin
            slotValid <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                slotDst[k] <= '0;
                slotRdy[k] <= '0;
            end
        end else if (bus.freeze) begin
            if (bus.kill1) begin
                slotValid[1] <= 1'b0;
            end
        end else begin
            for (int k = DEPTH; k >= 2; k--) begin
                slotValid[k] <= slotValid[k-1];
                slotDst[k]   <= slotDst[k-1];
                slotRdy[k]   <= slotRdy[k-1];
            end
            // Squashed MEM entry travels on as a bubble.
            slotValid[2] <= slotValid[1] & ~bus.kill1;
            // Writers to r0 or with no result are never tracked; a stalled
            // EXE instruction leaves a bubble behind it.
            slotValid[1] <= bus.ex_issue & ~stallReq
                            & (bus.ex_rdy != '0) & (bus.ex_dst != '0);
            slotDst[1]   <= bus.ex_dst;
            slotRdy[1]   <= bus.ex_rdy;
        end
    end

`ifdef FWD_SCOREBOARD_STALL_CNT_EN
    logic [31:0] stallCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt <= '0;
        end else if (stall_cnt_clr) begin
            stallCnt <= '0;
        end else if (stallReq && !bus.freeze && (stallCnt != 32'hFFFF_FFFF)) begin
            stallCnt <= stallCnt + 32'd1;
        end
    end

    assign stall_cnt = stallCnt;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - scoreboard-style directed bench for fwd_scoreboard
module tb_fwd_scoreboard;

    localparam int REGW  = 5;
    localparam int NSRC  = 2;
    localparam int DEPTH = 2;
    localparam int FWDW  = 3;

    localparam logic [2:0] RF = 3'b001;
    localparam logic [2:0] S1 = 3'b010;
    localparam logic [2:0] S2 = 3'b100;

    typedef struct {
        string       nm;
        logic [5:0]  sel;
        logic        stall;
        logic [1:0]  valid;
        int          cnt;
    } exp_t;

    logic clk;
    logic rst;
    logic stallCntClr;
    logic [31:0] stallCnt;

    int checks   = 0;
    int failures = 0;
    exp_t expQ[$];

    fwd_scoreboard_if #(.REGW(REGW), .NSRC(NSRC), .DEPTH(DEPTH), .FWDW(FWDW)) bus ();

    fwd_scoreboard #(.REGW(REGW), .NSRC(NSRC), .DEPTH(DEPTH), .FWDW(FWDW)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave)
`ifdef FWD_SCOREBOARD_STALL_CNT_EN
        ,
        .stall_cnt_clr (stallCntClr),
        .stall_cnt     (stallCnt)
`endif
    );

`ifndef FWD_SCOREBOARD_STALL_CNT_EN
    assign stallCnt = 32'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of stimulus and queue the response expected during it.
    task automatic step(input string nm, input bit iss, input int dst, input int rdy,
                        input int s0, input int s1, input bit [1:0] imm,
                        input bit kill, input bit frz, input bit rs, input bit clr,
                        input logic [2:0] e0, input logic [2:0] e1,
                        input bit es, input logic [1:0] ev, input int ec);
        exp_t e;
        @(posedge clk);
        #1;
        rst            = rs;
        stallCntClr    = clr;
        bus.ex_issue   = iss;
        bus.ex_dst     = REGW'(dst);
        bus.ex_rdy     = FWDW'(rdy);
        bus.ex_src     = {REGW'(s1), REGW'(s0)};
        bus.ex_src_imm = imm;
        bus.kill1      = kill;
        bus.freeze     = frz;
        e.nm    = nm;
        e.sel   = {e1, e0};
        e.stall = es;
        e.valid = ev;
        e.cnt   = ec;
        expQ.push_back(e);
    endtask

    // Monitor: compares the combinational response mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checks++;
            if (bus.fwd_sel !== e.sel) begin
                failures++;
                $display("FAIL %s fwd_sel got=%b want=%b", e.nm, bus.fwd_sel, e.sel);
            end
            checks++;
            if (bus.stall_req !== e.stall) begin
                failures++;
                $display("FAIL %s stall_req got=%b want=%b", e.nm, bus.stall_req, e.stall);
            end
            checks++;
            if (bus.slot_valid !== e.valid) begin
                failures++;
                $display("FAIL %s slot_valid got=%b want=%b", e.nm, bus.slot_valid, e.valid);
            end
            for (int i = 0; i < NSRC; i++) begin
                checks++;
                if (!$onehot(bus.fwd_sel[i*3 +: 3])) begin
                    failures++;
                    $display("FAIL %s onehot op%0d got=%b want=one-hot", e.nm, i, bus.fwd_sel[i*3 +: 3]);
                end
            end
`ifdef FWD_SCOREBOARD_STALL_CNT_EN
            if (e.cnt >= 0) begin
                checks++;
                if (stallCnt !== 32'(e.cnt)) begin
                    failures++;
                    $display("FAIL %s stall_cnt got=%0d want=%0d", e.nm, stallCnt, e.cnt);
                end
            end
`endif
        end
    end

    initial begin
        rst = 1'b1; stallCntClr = 1'b0;
        bus.ex_issue = 0; bus.ex_dst = 0; bus.ex_rdy = 0; bus.ex_src = 0;
        bus.ex_src_imm = 0; bus.kill1 = 0; bus.freeze = 0;
        repeat (2) @(posedge clk);
        //    name            iss dst rdy s0  s1  imm kl fz rs cl  op0 op1 st valid cnt
        step("reset",         0,  0,  0,  0,  0,  0,  0, 0, 0, 0, RF, RF, 0, 2'b00,  0);
        step("alu_issue",     1,  3,  1,  0,  0,  0,  0, 0, 0, 0, RF, RF, 0, 2'b00, -1);
        step("alu_fwd_s1",    0,  0,  0,  3,  0,  0,  0, 0, 0, 0, S1, RF, 0, 2'b01, -1);
        step("alu_fwd_s2",    0,  0,  0,  3,  0,  0,  0, 0, 0, 0, S2, RF, 0, 2'b10, -1);
        step("lw_issue",      1,  5,  2,  0,  0,  0,  0, 0, 0, 0, RF, RF, 0, 2'b00, -1);
        step("lw_use_stall",  1,  6,  1,  0,  5,  0,  0, 0, 0, 0, RF, RF, 1, 2'b01, -1);
        step("lw_use_fwd",    0,  0,  0,  0,  5,  0,  0, 0, 0, 0, RF, S2, 0, 2'b10, -1);
        step("y_issue_a",     1,  7,  1,  0,  0,  0,  0, 0, 0, 0, RF, RF, 0, 2'b00, -1);
        step("y_issue_b",     1,  7,  2,  0,  0,  0,  0, 0, 0, 0, RF, RF, 0, 2'b01, -1);
        step("y_young_stall", 0,  0,  0,  7,  0,  0,  0, 0, 0, 0, RF, RF, 1, 2'b11, -1);
        step("y_issue_c",     1,  7,  1,  0,  0,  0,  0, 0, 0, 0, RF, RF, 0, 2'b10, -1);
        step("y_issue_d",     1,  7,  1,  0,  0,  0,  0, 0, 0, 0, RF, RF, 0, 2'b01, -1);
        step("y_young_fwd",   0,  0,  0,  7,  0,  0,  0, 0, 0, 0, S1, RF, 0, 2'b11, -1);
        step("m_issue",       1,  4,  1,  0,  0,  0,  0, 0, 0, 0, RF, RF, 0, 2'b10, -1);
        step("m_r0_imm",      0,  0,  0,  0,  4,  2,  0, 0, 0, 0, RF, RF, 0, 2'b01, -1);
        step("m_issue_nores", 1,  4,  0,  0,  0,  0,  0, 0, 0, 0, RF, RF, 0, 2'b10, -1);
        step("m_nores",       1,  0,  1,  4,  0,  0,  0, 0, 0, 0, RF, RF, 0, 2'b00, -1);
        step("m_dst_r0",      0,  0,  0,  0,  0,  0,  0, 0, 0, 0, RF, RF, 0, 2'b00, -1);
        step("far_issue",     1,  9,  3,  0,  0,  0,  0, 0, 0, 0, RF, RF, 0, 2'b00, -1);
        step("far_stall1",    1, 10,  1,  9,  0,  0,  0, 0, 0, 0, RF, RF, 1, 2'b01, -1);
        step("far_stall2",    0,  0,  0,  9,  0,  0,  0, 0, 0, 0, RF, RF, 1, 2'b10, -1);
        step("far_retired",   0,  0,  0,  9, 10,  0,  0, 0, 0, 0, RF, RF, 0, 2'b00, -1);
        step("fz_issue_a",    1, 11,  1,  0,  0,  0,  0, 0, 0, 0, RF, RF, 0, 2'b00, -1);
        step("fz_issue_b",    1, 12,  1,  0,  0,  0,  0, 0, 0, 0, RF, RF, 0, 2'b01, -1);
        step("fz_hold1",      1, 13,  1, 11,  0,  0,  0, 1, 0, 0, S2, RF, 0, 2'b11, -1);
        step("fz_hold2",      1, 13,  1, 12,  0,  0,  0, 1, 0, 0, S1, RF, 0, 2'b11, -1);
        step("fz_hold_kill",  1, 13,  1,  0,  0,  0,  1, 1, 0, 0, RF, RF, 0, 2'b11, -1);
        step("fz_killed",     0,  0,  0, 12, 11,  0,  0, 0, 0, 0, RF, S2, 0, 2'b10, -1);
        step("k_issue",       1, 14,  1,  0,  0,  0,  0, 0, 0, 0, RF, RF, 0, 2'b00, -1);
        step("k_kill",        0,  0,  0, 14,  0,  0,  1, 0, 0, 0, S1, RF, 0, 2'b01, -1);
        step("k_killed",      0,  0,  0, 14,  0,  0,  0, 0, 0, 0, RF, RF, 0, 2'b00, -1);
        step("r_issue",       1, 15,  3,  0,  0,  0,  0, 0, 0, 0, RF, RF, 0, 2'b00, -1);
        step("r_frozen",      0,  0,  0, 15,  0,  0,  0, 1, 0, 0, RF, RF, 0, 2'b01, -1);
        step("r_stall",       0,  0,  0, 15,  0,  0,  0, 0, 0, 0, RF, RF, 1, 2'b01, -1);
        step("r_rst",         0,  0,  0, 15,  0,  0,  0, 0, 1, 0, RF, RF, 1, 2'b10, -1);
        step("r_after",       0,  0,  0, 15,  0,  0,  0, 0, 0, 0, RF, RF, 0, 2'b00,  0);
        step("c_issue_a",     1, 16,  3,  0,  0,  0,  0, 0, 0, 0, RF, RF, 0, 2'b00, -1);
        step("c_stall1",      0,  0,  0, 16,  0,  0,  0, 0, 0, 0, RF, RF, 1, 2'b01, -1);
        step("c_frozen",      0,  0,  0, 16,  0,  0,  0, 1, 0, 0, RF, RF, 0, 2'b10, -1);
        step("c_stall2",      0,  0,  0, 16,  0,  0,  0, 0, 0, 0, RF, RF, 1, 2'b10, -1);
        step("c_issue_b",     1, 17,  3,  0,  0,  0,  0, 0, 0, 0, RF, RF, 0, 2'b00, -1);
        step("c_stall3",      0,  0,  0, 17,  0,  0,  0, 0, 0, 0, RF, RF, 1, 2'b01, -1);
        step("c_count",       0,  0,  0,  0,  0,  0,  0, 0, 0, 0, RF, RF, 0, 2'b10,  3);
        step("clr_issue",     1, 18,  3,  0,  0,  0,  0, 0, 0, 0, RF, RF, 0, 2'b00, -1);
        step("clr_stall",     0,  0,  0, 18,  0,  0,  0, 0, 0, 1, RF, RF, 1, 2'b01,  3);
        step("clr_check",     0,  0,  0,  0,  0,  0,  0, 0, 0, 0, RF, RF, 0, 2'b10,  0);
        for (int n = 0; n < 20 && expQ.size() > 0; n++) @(posedge clk);
        if (expQ.size() > 0) begin
            failures++;
            $display("FAIL drain got=%0d want=0 pending", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised forwarding/hazard unit for the EXE stage; successor to the fixed two-operand MEM/WB forwarding logic.
- Tracks in-flight results in a DEPTH-slot shift scoreboard (slot 1 = MEM, slot 2 = WB, further slots = extra late stages).
- Produces a one-hot bypass select for each of NSRC ALU operands, and a load-use stall request when the youngest producer's data is not yet available.

Parameters:
- REGW, 5, register-number width.
- NSRC, 2, number of EXE source operands.
- DEPTH, 2, number of tracked post-EXE stages (min 2, max 6).
- FWDW, 3, width of the ready-stage code.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  pipeline frozen; scoreboard holds.
- ex_issue  in  1  the EXE instruction advances into slot 1 this cycle.
- ex_dst  in  REGW  destination register of the EXE instruction.
- ex_rdy  in  FWDW  earliest slot whose data is forwardable; 0 = no result (NONE).
- ex_src  in  NSRC*REGW  operand register numbers, operand i at bits [i*REGW +: REGW].
- ex_src_imm  in  NSRC  per operand: 1 = immediate, never forwarded.
- kill1  in  1  squash the slot-1 entry.
- fwd_sel  out  NSRC*(DEPTH+1)  per operand, one-hot; bit 0 = regfile, bit k = slot k.
- stall_req  out  1  load-use stall.
- slot_valid  out  DEPTH  valid bit per slot (debug/verification).

Behaviour:
- Slot state per entry: valid, dst[REGW-1:0], rdy[FWDW-1:0].
- Reset (synchronous): all valid=0.
  - Outputs after reset: fwd_sel = bit 0 only per operand, stall_req = 0, slot_valid = 0.
- Each rising edge with rst=0 and freeze=0:
  - slot k+1 <= slot k for k = 1..DEPTH-1.
  - The oldest slot retires.
  - slot 1 <= {ex_issue & ~stall_req & (ex_rdy != 0) & (ex_dst != 0), ex_dst, ex_rdy}.
  - While stall_req=1, a bubble (valid=0) enters slot 1.
- freeze=1: no state change. Outputs still evaluate combinationally.
- kill1=1 with freeze=0: the entry shifting out of slot 1 into slot 2 has valid forced to 0.
- kill1=1 with freeze=1: slot 1 valid cleared in place.
- rst has priority over freeze and kill1. Reset mid-operation discards all entries in one cycle.
- Operand resolution (combinational, zero latency):
  - Match at slot k: valid & dst == src & src != 0 & ~src_imm.
  - The youngest (lowest k) match wins.
  - If the winner has k >= rdy: fwd_sel bit k = 1.
  - If the winner has k < rdy: stall_req = 1 and fwd_sel = bit 0.
  - No match: fwd_sel = bit 0.
  - Older matches never override a younger non-ready match; stale data must not be forwarded.
- rdy > DEPTH: the entry can never forward. A matching operand stalls until the entry retires, then reads the regfile.
- stall_req is the OR over all operands, gated by ~freeze so a frozen pipe does not double-stall.
- fwd_sel is exactly one-hot at all times (checked by assertion in the bench).

Optional Feature:
- Macro: FWD_SCOREBOARD_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt [31:0].
  - Increments on every clock edge with stall_req=1 and freeze=0; saturates at 32'hFFFF_FFFF.
  - Reset to 0 by rst.
  - Adds input stall_cnt_clr: synchronous clear, priority over increment.
- Undefined: neither port exists and no counter logic is generated. All other behaviour is identical.

Test Plan:
- ALU chain, ex_issue: add r3 (rdy=1), next cycle src0=r3 -> fwd_sel[0] = 3'b010 (slot 1); one cycle later with no new writer, src0=r3 -> 3'b100 (slot 2).
- Load-use: lw r5 (rdy=2) issues, next cycle src1=r5 -> stall_req=1, fwd_sel[1] = 3'b001. Next cycle (bubble in slot 1, lw in slot 2) -> stall_req=0, fwd_sel[1] = 3'b100.
- Youngest wins: slot 2 holds r7 (rdy=1) and slot 1 holds r7 (rdy=2), src0=r7 -> stall_req=1, not slot-2 forward. Same with slot-1 rdy=1 -> fwd_sel = 3'b010.
- Masking: src=r0, or src_imm=1 with src matching slot 1 r4, or entry rdy=0 with dst=r4 -> fwd_sel = 3'b001, stall_req=0.
- freeze/kill: freeze for 3 cycles holds slot_valid=2'b11 unchanged. kill1 then unfreeze -> slot_valid=2'b10 after one edge, and a src matching the killed dst reads the regfile. rst asserted mid-stall -> slot_valid=0, stall_req=0 next cycle.
- With FWD_SCOREBOARD_STALL_CNT_EN: 4 stall cycles, 1 of them frozen -> stall_cnt=3. stall_cnt_clr plus stall in the same cycle -> 0. Preloaded 32'hFFFF_FFFF plus stall -> stays 32'hFFFF_FFFF.
